// File: rtl/control_fsm_decoder_pkg.sv
// Shared encodings for the multicycle controller: state enum, instruction
// field decodes and datapath select values.
package control_fsm_decoder_pkg;

    localparam int unsigned INSTR_W = 6;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC,
        ALUWB,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        BRANCH,
        BRLINK
    } state_t;

    localparam logic [1:0] TYPE_DATA = 2'b00;
    localparam logic [1:0] TYPE_MEM  = 2'b01;
    localparam logic [1:0] TYPE_BR   = 2'b10;
    localparam logic [1:0] TYPE_ILL  = 2'b11;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_CMP = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_ONE = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] FLAGW_ALL = 2'b11;
    localparam logic [1:0] FLAGW_NZ  = 2'b10;

    function automatic logic [1:0] instr_type(input logic [INSTR_W-1:0] instr);
        return instr[5:4];
    endfunction

endpackage

// File: rtl/control_fsm_decoder_alu_op_decode.sv
// Data-op decode: opcode -> ALU function, flag-update mask and compare's
// write suppression. Ungated; the controller qualifies these by state.
module control_fsm_decoder_alu_op_decode
    import control_fsm_decoder_pkg::*;
(
    input  logic [1:0] i_opcode,
    output logic [1:0] o_alu_control,
    output logic [1:0] o_flag_w,
    output logic       o_no_write
);

    always_comb begin
        o_alu_control = ALU_ADD;
        o_flag_w      = FLAGW_ALL;
        o_no_write    = 1'b0;
        case (i_opcode)
            OP_ADD: o_alu_control = ALU_ADD;
            OP_SUB: o_alu_control = ALU_SUB;
            OP_AND: begin
                o_alu_control = ALU_AND;
                o_flag_w      = FLAGW_NZ;
            end
            OP_CMP: begin
                // compare is a subtract whose result is discarded
                o_alu_control = ALU_SUB;
                o_no_write    = 1'b1;
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_fsm_decoder.sv
// Multicycle main controller: sequences fetch/decode/execute/memory/writeback
// and emits per-state control strobes. CONTROL_FSM_BL_EN adds branch-and-link.
module control_fsm_decoder
    import control_fsm_decoder_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] Instr,
    input  logic               MemReady,
    output logic               PCS,
    output logic               RegW,
    output logic               MemW,
    output logic               NoWrite,
    output logic [1:0]         FlagW,
    output logic               IRWrite,
    output logic               NextPC,
    output logic               AdrSrc,
    output logic               ALUSrcA,
    output logic [SEL_W-1:0]   ALUSrcB,
    output logic [SEL_W-1:0]   ResultSrc,
    output logic [1:0]         ALUControl,
    output logic               IllegalOp
`ifdef CONTROL_FSM_BL_EN
    ,
    output logic               LinkW
`endif
);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] w_type;
    logic       w_imm;
    logic       w_is_load;
    logic [1:0] w_alu_control;
    logic [1:0] w_flag_w;
    logic       w_no_write;
    logic       w_unused;

    assign w_type    = instr_type(Instr);
    assign w_imm     = Instr[3];
    assign w_is_load = Instr[1];
    assign w_unused  = Instr[0];

    control_fsm_decoder_alu_op_decode u_alu_op_decode (
        .i_opcode      (Instr[2:1]),
        .o_alu_control (w_alu_control),
        .o_flag_w      (w_flag_w),
        .o_no_write    (w_no_write)
    );

    always_ff @(posedge clk) begin
        if (!reset) r_state <= FETCH;
        else        r_state <= w_next;
    end

    // next state and Moore outputs; strobes forced low while reset is held
    always_comb begin
        w_next     = r_state;
        PCS        = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        NoWrite    = 1'b0;
        FlagW      = 2'b00;
        IRWrite    = 1'b0;
        NextPC     = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        ResultSrc  = RES_ALUOUT;
        ALUControl = ALU_ADD;
        IllegalOp  = 1'b0;
`ifdef CONTROL_FSM_BL_EN
        LinkW      = 1'b0;
`endif
        case (r_state)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_ONE;
                ResultSrc = RES_ALU;
                IRWrite   = MemReady;
                NextPC    = MemReady;
                if (MemReady) w_next = DECODE;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_ONE;
                ResultSrc = RES_ALU;
                case (w_type)
                    TYPE_DATA: w_next = EXEC;
                    TYPE_MEM:  w_next = MEMADR;
                    TYPE_BR:   w_next = BRANCH;
                    default: begin
                        IllegalOp = 1'b1;
                        w_next    = FETCH;
                    end
                endcase
            end
            EXEC: begin
                ALUSrcB    = w_imm ? SRCB_IMM : SRCB_REG;
                ALUControl = w_alu_control;
                FlagW      = w_flag_w;
                w_next     = ALUWB;
            end
            ALUWB: begin
                RegW    = 1'b1;
                NoWrite = w_no_write;
                w_next  = FETCH;
            end
            MEMADR: begin
                ALUSrcB = SRCB_IMM;
                w_next  = w_is_load ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc = 1'b1;
                if (MemReady) w_next = MEMWB;
            end
            MEMWB: begin
                RegW      = 1'b1;
                ResultSrc = RES_RDATA;
                w_next    = FETCH;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = MemReady;
                if (MemReady) w_next = FETCH;
            end
            BRANCH: begin
                PCS       = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALU;
`ifdef CONTROL_FSM_BL_EN
                w_next    = w_imm ? BRLINK : FETCH;
`else
                w_next    = FETCH;
`endif
            end
            BRLINK: begin
                RegW      = 1'b1;
                ResultSrc = RES_ALU;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_ONE;
`ifdef CONTROL_FSM_BL_EN
                LinkW     = 1'b1;
`endif
                w_next    = FETCH;
            end
            default: w_next = FETCH;
        endcase
        if (!reset) begin
            PCS       = 1'b0;
            RegW      = 1'b0;
            MemW      = 1'b0;
            FlagW     = 2'b00;
            IRWrite   = 1'b0;
            NextPC    = 1'b0;
            IllegalOp = 1'b0;
`ifdef CONTROL_FSM_BL_EN
            LinkW     = 1'b0;
`endif
        end
    end

endmodule
